// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access pipeline stage:
//   - funct3 encodings for load/store access size and signedness
//   - FSM state encoding for stage_mem
//   - helpers that derive byte enables, store lanes and the misalignment rule
// -----------------------------------------------------------------------------
package mem_pkg;

    // Access size/sign encodings carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2
    } mem_state_e;

    // Bits [1:0] of funct3 give the access size; bit 2 only selects signedness.
    function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                                input logic [1:0] offset);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] sd);
        logic [31:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{sd[7:0]}};
            2'b01:   lanes = {2{sd[15:0]}};
            default: lanes = sd;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = offset[0];
            2'b10:   bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the byte/halfword lane addressed by the
// low address bits out of the returned word and sign- or zero-extends it.
// Ports:
//   rdata   in  32  word returned by data memory
//   offset  in  2   address bits [1:0] of the load
//   funct3  in  3   access size/sign (B, H, W, BU, HU)
//   result  out 32  formatted write-back value
// -----------------------------------------------------------------------------
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem
// Memory-access pipeline stage. Issues loads/stores on a request/grant/response
// data-memory port, stalls the pipeline while an access is in flight and
// presents the write-back value (formatted load data or ALU result).
//
// Memory port handshake: o_dmem_req is a request that, once raised, holds
// addr/we/be/wdata stable until the cycle i_dmem_gnt is seen high with it; that
// cycle transfers the request. A granted load is answered later by exactly one
// i_dmem_rvalid pulse (never in the grant cycle) carrying i_dmem_rdata.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_valid               EX/MEM slot holds a live instruction
//   i_mem_read/_write     load / store
//   i_funct3              access size and sign
//   i_alu_result          effective address or non-memory result
//   i_store_data          forwarded rs2
//   i_flush               kill current instruction
//   o_dmem_*              request side of data-memory port
//   i_dmem_gnt/rvalid/rdata  grant and response side
//   o_wb_data             value for MEM/WB
//   o_stall               freeze upstream stages, bubble MEM/WB
//   o_misaligned          access misaligned for its size
//   o_state               current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module stage_mem
    import mem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic        i_flush,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_wb_data,
    output logic        o_stall,
    output logic        o_misaligned,
    output mem_state_e  o_state
);

    mem_state_e  state, next_state;
    logic [1:0]  cap_offset;
    logic [2:0]  cap_funct3;
    logic        capture;

    logic        mem_op;
    logic        misaligned;
    logic        req;
    logic        stall;
    logic [31:0] wb_data;
    logic [31:0] load_result;

    assign mem_op     = i_valid & (i_mem_read | i_mem_write);
    assign misaligned = mem_op & is_misaligned(i_funct3, i_alu_result[1:0]);

    load_align u_load_align (
        .rdata  (i_dmem_rdata),
        .offset (cap_offset),
        .funct3 (cap_funct3),
        .result (load_result)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            cap_offset <= 2'b00;
            cap_funct3 <= 3'b000;
        end else begin
            state <= next_state;
            if (capture) begin
                cap_offset <= i_alu_result[1:0];
                cap_funct3 <= i_funct3;
            end
        end
    end

    always_comb begin
        next_state = state;
        req        = 1'b0;
        stall      = 1'b0;
        capture    = 1'b0;
        wb_data    = i_alu_result;
        case (state)
            IDLE: begin
                if (mem_op && !misaligned && !i_flush) begin
                    req = 1'b1;
                    if (!i_dmem_gnt) begin
                        stall = 1'b1;
                    end else if (i_mem_read) begin
                        capture    = 1'b1;
                        stall      = 1'b1;
                        next_state = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (i_dmem_rvalid) begin
                    wb_data    = load_result;
                    next_state = IDLE;
                end else if (i_flush) begin
                    // Response still owed by memory; swallow it in DRAIN.
                    next_state = DRAIN;
                end else begin
                    stall = 1'b1;
                end
            end
            DRAIN: begin
                // Hold everything off so a new access cannot overtake the
                // outstanding response.
                stall = 1'b1;
                if (i_dmem_rvalid) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held so an abandoned access
    // disappears from the port immediately.
    always_comb begin
        o_dmem_req   = req & ~i_reset;
        o_dmem_we    = req & i_mem_write & ~i_reset;
        o_dmem_be    = (req & ~i_reset) ? byte_enables(i_funct3, i_alu_result[1:0]) : 4'b0000;
        o_dmem_addr  = {i_alu_result[31:2], 2'b00};
        o_dmem_wdata = store_lanes(i_funct3, i_store_data);
        o_stall      = stall & ~i_reset;
        o_misaligned = (state == IDLE) & misaligned & ~i_reset;
        o_wb_data    = wb_data;
        o_state      = state;
    end

endmodule

// File: tb/tb_stage_mem.sv
// -----------------------------------------------------------------------------
// tb_stage_mem
// Directed bench for stage_mem. Inputs change 1 time unit after a rising edge
// and outputs are sampled 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_stage_mem;
    import mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    logic        i_valid, i_mem_read, i_mem_write, i_flush;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result, i_store_data;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_wb_data;
    logic        o_stall, o_misaligned;
    mem_state_e  o_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Expected load results, pushed when the load is issued, popped at rvalid
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    stage_mem dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_funct3      (i_funct3),
        .i_alu_result  (i_alu_result),
        .i_store_data  (i_store_data),
        .i_flush       (i_flush),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_be     (o_dmem_be),
        .i_dmem_gnt    (i_dmem_gnt),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_wb_data     (o_wb_data),
        .o_stall       (o_stall),
        .o_misaligned  (o_misaligned),
        .o_state       (o_state)
    );

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_op(input logic valid, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] sd);
        i_valid      = valid;
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_funct3     = f3;
        i_alu_result = alu;
        i_store_data = sd;
    endtask

    task automatic set_mem(input logic gnt, input logic rv, input logic [31:0] rd);
        i_dmem_gnt    = gnt;
        i_dmem_rvalid = rv;
        i_dmem_rdata  = rd;
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input mem_state_e exp);
        check(tag, 32'(o_state), 32'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        i_reset = 1'b1;
        i_flush = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0);
        set_mem(1'b0, 1'b0, 32'h0);
        next_cycle();
        #1;
        check("rst_req",   32'(o_dmem_req),   32'd0);
        check("rst_stall", 32'(o_stall),      32'd0);
        check("rst_mis",   32'(o_misaligned), 32'd0);
        check("rst_be",    32'(o_dmem_be),    32'd0);
        check("rst_we",    32'(o_dmem_we),    32'd0);
        check("rst_wb",    o_wb_data,         32'h0000_0055);
        check_state("rst_state", IDLE);
        next_cycle();
        i_reset = 1'b0;
        next_cycle();

        // SW 0x104, immediate grant
        set_op(1'b1, 1'b0, 1'b1, F3_W, 32'h0000_0104, 32'hDEAD_BEEF);
        set_mem(1'b1, 1'b0, 32'h0);
        #1;
        check("sw_req",   32'(o_dmem_req), 32'd1);
        check("sw_we",    32'(o_dmem_we),  32'd1);
        check("sw_addr",  o_dmem_addr,     32'h0000_0104);
        check("sw_be",    32'(o_dmem_be),  32'hF);
        check("sw_wdata", o_dmem_wdata,    32'hDEAD_BEEF);
        check("sw_stall", 32'(o_stall),    32'd0);
        next_cycle();
        check_state("sw_state", IDLE);

        // SB 0x103
        set_op(1'b1, 1'b0, 1'b1, F3_B, 32'h0000_0103, 32'h0000_00A5);
        #1;
        check("sb_be",    32'(o_dmem_be), 32'h8);
        check("sb_wdata", o_dmem_wdata,   32'hA5A5_A5A5);
        check("sb_addr",  o_dmem_addr,    32'h0000_0100);
        check("sb_stall", 32'(o_stall),   32'd0);
        next_cycle();

        // LB 0x102 then LBU 0x102: grant cycle 0, rvalid cycle 2
        for (int k = 0; k < 2; k++) begin
            set_op(1'b1, 1'b1, 1'b0, (k == 0) ? F3_B : F3_BU, 32'h0000_0102, 32'h0);
            exp_q.push_back((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            set_mem(1'b1, 1'b0, 32'h0);
            #1;
            check("lb_req_c0",   32'(o_dmem_req), 32'd1);
            check("lb_we_c0",    32'(o_dmem_we),  32'd0);
            check("lb_be_c0",    32'(o_dmem_be),  32'h4);
            check("lb_stall_c0", 32'(o_stall),    32'd1);
            next_cycle();
            set_mem(1'b0, 1'b0, 32'h0);
            #1;
            check_state("lb_state_c1", WAIT_RSP);
            check("lb_stall_c1", 32'(o_stall),    32'd1);
            check("lb_req_c1",   32'(o_dmem_req), 32'd0);
            next_cycle();
            set_mem(1'b0, 1'b1, 32'h1180_0033);
            #1;
            exp_v = exp_q.pop_front();
            check("lb_stall_c2", 32'(o_stall), 32'd0);
            check("lb_wb_c2",    o_wb_data,    exp_v);
            next_cycle();
            set_mem(1'b0, 1'b0, 32'h0);
            set_op(1'b0, 1'b0, 1'b0, F3_W, 32'h0000_0777, 32'h0);
            #1;
            check_state("lb_state_c3", IDLE);
            check("lb_wb_c3", o_wb_data, 32'h0000_0777);
        end

        // LH 0x101: misaligned
        set_op(1'b1, 1'b1, 1'b0, F3_H, 32'h0000_0101, 32'h0);
        set_mem(1'b1, 1'b0, 32'h0);
        #1;
        check("lh_mis",   32'(o_misaligned), 32'd1);
        check("lh_req",   32'(o_dmem_req),   32'd0);
        check("lh_stall", 32'(o_stall),      32'd0);
        check("lh_wb",    o_wb_data,         32'h0000_0101);
        // LW 0x102 also misaligned, SW 0x100 is not
        set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0102, 32'h0);
        #1;
        check("lw_mis", 32'(o_misaligned), 32'd1);
        set_op(1'b1, 1'b0, 1'b1, F3_W, 32'h0000_0100, 32'h0);
        #1;
        check("sw_aligned_mis", 32'(o_misaligned), 32'd0);
        next_cycle();

        // Flush in IDLE suppresses request and stall
        set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0);
        set_mem(1'b0, 1'b0, 32'h0);
        i_flush = 1'b1;
        #1;
        check("idle_flush_req",   32'(o_dmem_req), 32'd0);
        check("idle_flush_stall", 32'(o_stall),    32'd0);
        next_cycle();
        i_flush = 1'b0;

        // LW 0x200 granted, flushed next cycle, rvalid two cycles later
        set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0200, 32'h0);
        set_mem(1'b1, 1'b0, 32'h0);
        #1;
        check("lwf_stall_c0", 32'(o_stall), 32'd1);
        next_cycle();
        set_mem(1'b0, 1'b0, 32'h0);
        i_flush = 1'b1;
        #1;
        check("lwf_stall_c1", 32'(o_stall), 32'd0);
        next_cycle();
        i_flush = 1'b0;
        set_op(1'b1, 1'b0, 1'b1, F3_W, 32'h0000_0400, 32'h1234_5678);
        #1;
        check_state("lwf_state_c2", DRAIN);
        check("lwf_req_c2",   32'(o_dmem_req), 32'd0);
        check("lwf_stall_c2", 32'(o_stall),    32'd1);
        next_cycle();
        set_mem(1'b0, 1'b1, 32'hCAFE_F00D);
        #1;
        check("lwf_req_c3",   32'(o_dmem_req), 32'd0);
        check("lwf_stall_c3", 32'(o_stall),    32'd1);
        next_cycle();
        set_mem(1'b1, 1'b0, 32'h0);
        #1;
        check_state("lwf_state_c4", IDLE);
        check("lwf_req_c4",   32'(o_dmem_req), 32'd1);
        check("lwf_addr_c4",  o_dmem_addr,     32'h0000_0400);
        check("lwf_stall_c4", 32'(o_stall),    32'd0);
        next_cycle();

        // LH / LHU at 0x106: upper half of 0xBEEF1234; second one sees flush+rvalid
        for (int k = 0; k < 2; k++) begin
            set_op(1'b1, 1'b1, 1'b0, (k == 0) ? F3_H : F3_HU, 32'h0000_0106, 32'h0);
            exp_q.push_back((k == 0) ? 32'hFFFF_BEEF : 32'h0000_BEEF);
            set_mem(1'b1, 1'b0, 32'h0);
            #1;
            check("lh_be", 32'(o_dmem_be), 32'hC);
            next_cycle();
            set_mem(1'b0, 1'b1, 32'hBEEF_1234);
            i_flush = (k == 1);
            #1;
            exp_v = exp_q.pop_front();
            check("lh_wb",    o_wb_data,    exp_v);
            check("lh_stall", 32'(o_stall), 32'd0);
            next_cycle();
            i_flush = 1'b0;
            set_mem(1'b0, 1'b0, 32'h0);
            set_op(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
            #1;
            check_state("lh_state_after", IDLE);
        end

        // SH 0x202 with grant withheld for 3 cycles
        set_op(1'b1, 1'b0, 1'b1, F3_H, 32'h0000_0202, 32'h0000_1234);
        set_mem(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("sh_req",   32'(o_dmem_req), 32'd1);
            check("sh_be",    32'(o_dmem_be),  32'hC);
            check("sh_addr",  o_dmem_addr,     32'h0000_0200);
            check("sh_wdata", o_dmem_wdata,    32'h1234_1234);
            check("sh_stall", 32'(o_stall),    32'd1);
            next_cycle();
        end
        set_mem(1'b1, 1'b0, 32'h0);
        #1;
        check("sh_gnt_stall", 32'(o_stall), 32'd0);
        next_cycle();

        // Reset while a load waits for its response
        set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0500, 32'h0);
        set_mem(1'b1, 1'b0, 32'h0);
        next_cycle();
        set_mem(1'b0, 1'b0, 32'h0);
        #1;
        check_state("rw_state_pre", WAIT_RSP);
        #1;
        i_reset = 1'b1;
        #1;
        check_state("rw_state_rst", IDLE);
        check("rw_req_rst",   32'(o_dmem_req), 32'd0);
        check("rw_stall_rst", 32'(o_stall),    32'd0);
        next_cycle();
        i_reset = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, F3_W, 32'h0000_0999, 32'h0);
        set_mem(1'b0, 1'b1, 32'h8765_4321);
        #1;
        check("late_rv_stall", 32'(o_stall), 32'd0);
        check("late_rv_wb",    o_wb_data,    32'h0000_0999);
        next_cycle();
        set_mem(1'b0, 1'b0, 32'h0);
        #1;
        check_state("late_rv_state", IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
